// File: rtl/pll_clkdiv_gen.sv
// Post-PLL clock generator: NUM_CH programmable dividers with phase strobes,
// lock-gated staggered reset release and a glitch-free valid/ready reconfiguration port.
module pll_clkdiv_gen #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int DEF_DIV     = 1,
    parameter int LOCK_CYCLES = 16,
    parameter int RST_STAGGER = 4,
    parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    input  logic              cfg_en,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] clk_en,
    output logic [NUM_CH-1:0] rst_out,
    output logic              extlock
);

    localparam int SCW = $clog2(LOCK_CYCLES + 1);
    localparam int GCW = $clog2(RST_STAGGER + 1);
    localparam int unsigned NCH = NUM_CH;

    typedef enum logic [1:0] {ST_RESET, ST_SETTLE, ST_RELEASE, ST_RUN} state_t;

    state_t             state;
    logic [SCW-1:0]     settle_cnt;
    logic [GCW-1:0]     stg_cnt;
    logic [CH_W-1:0]    rel_idx;

    logic               pend;
    logic [CH_W-1:0]    pend_ch;
    logic [DIV_W-1:0]   pend_div;
    logic [DIV_W-1:0]   pend_phase;
    logic               pend_en;

    logic [DIV_W-1:0]   cnt     [NUM_CH];
    logic [DIV_W-1:0]   div     [NUM_CH];
    logic [DIV_W-1:0]   phase   [NUM_CH];
    logic [NUM_CH-1:0]  en;

    logic [DIV_W-1:0]   cnt_n   [NUM_CH];
    logic [DIV_W-1:0]   div_n   [NUM_CH];
    logic [DIV_W-1:0]   phase_n [NUM_CH];
    logic [NUM_CH-1:0]  en_n;
    logic [NUM_CH-1:0]  clk_out_n;
    logic [NUM_CH-1:0]  clk_en_n;

    logic               accept;
    logic               in_range;
    logic               commit;
    logic [CH_W:0]      first_hit;
    logic [CH_W:0]      next_hit;

    // Lowest enabled channel index >= start, returned as {found, index}.
    function automatic logic [CH_W:0] find_en(input logic [NUM_CH-1:0] mask,
                                              input int unsigned start);
        logic            found;
        logic [CH_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!found && mask[i] && i >= start) begin
                found = 1'b1;
                idx   = CH_W'(i);
            end
        end
        return {found, idx};
    endfunction

    assign accept    = cfg_valid && cfg_ready;
    assign in_range  = 32'(cfg_ch) < NCH;
    // The target swaps settings only at the end of its current period, so no runt pulse.
    assign commit    = pend && (cnt[pend_ch] == div[pend_ch] || !en[pend_ch] || div[pend_ch] == '0);
    assign first_hit = find_en(en, 0);
    assign next_hit  = find_en(en, 32'(rel_idx) + 1);

    always_comb begin : ch_next
        logic             tgt;
        logic [DIV_W-1:0] ph_eff;
        tgt    = 1'b0;
        ph_eff = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            tgt        = commit && (pend_ch == CH_W'(i));
            div_n[i]   = tgt ? pend_div   : div[i];
            phase_n[i] = tgt ? pend_phase : phase[i];
            en_n[i]    = tgt ? pend_en    : en[i];
            if (!en_n[i] || tgt || cnt[i] >= div[i])
                cnt_n[i] = '0;
            else
                cnt_n[i] = cnt[i] + 1'b1;
            ph_eff       = (phase_n[i] < div_n[i]) ? phase_n[i] : div_n[i];
            clk_out_n[i] = en_n[i] && (cnt_n[i] <= (div_n[i] >> 1));
            clk_en_n[i]  = en_n[i] && (cnt_n[i] == ph_eff);
        end
    end

    always_ff @(posedge refclk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt[i]   <= '0;
                div[i]   <= DIV_W'(DEF_DIV);
                phase[i] <= '0;
            end
            en      <= '1;
            clk_out <= '0;
            clk_en  <= '0;
        end else begin
            cnt     <= cnt_n;
            div     <= div_n;
            phase   <= phase_n;
            en      <= en_n;
            clk_out <= clk_out_n;
            clk_en  <= clk_en_n;
        end
    end

    always_ff @(posedge refclk) begin
        if (reset) begin
            state      <= ST_RESET;
            settle_cnt <= '0;
            stg_cnt    <= '0;
            rel_idx    <= '0;
            extlock    <= 1'b0;
            rst_out    <= '1;
            cfg_ready  <= 1'b0;
            pend       <= 1'b0;
            pend_ch    <= '0;
            pend_div   <= '0;
            pend_phase <= '0;
            pend_en    <= 1'b0;
        end else begin
            // Sequencing freezes while an update is pending; the commit restarts it from SETTLE.
            case (state)
                ST_RESET: begin
                    state      <= ST_SETTLE;
                    settle_cnt <= '0;
                end
                ST_SETTLE: if (!pend) begin
                    if (settle_cnt == SCW'(LOCK_CYCLES - 1)) begin
                        extlock <= 1'b1;
                        if (first_hit[CH_W]) begin
                            rst_out[first_hit[CH_W-1:0]] <= 1'b0;
                            rel_idx <= first_hit[CH_W-1:0];
                            stg_cnt <= '0;
                            state   <= ST_RELEASE;
                        end else begin
                            state <= ST_RUN;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_RELEASE: if (!pend) begin
                    if (!next_hit[CH_W]) begin
                        state <= ST_RUN;
                    end else if (stg_cnt == GCW'(RST_STAGGER - 1)) begin
                        rst_out[next_hit[CH_W-1:0]] <= 1'b0;
                        rel_idx <= next_hit[CH_W-1:0];
                        stg_cnt <= '0;
                    end else begin
                        stg_cnt <= stg_cnt + 1'b1;
                    end
                end
                default: ;
            endcase

            if (commit) begin
                pend       <= 1'b0;
                cfg_ready  <= 1'b1;
                state      <= ST_SETTLE;
                settle_cnt <= '0;
            end else if (accept) begin
                cfg_ready <= !in_range;
                if (in_range) begin
                    pend       <= 1'b1;
                    pend_ch    <= cfg_ch;
                    pend_div   <= cfg_div;
                    pend_phase <= cfg_phase;
                    pend_en    <= cfg_en;
                    extlock    <= 1'b0;
                    rst_out    <= '1;
                end
            end else begin
                cfg_ready <= !pend;
            end
        end
    end

endmodule

// File: tb/tb_pll_clkdiv_gen.sv
// Directed bench for pll_clkdiv_gen: lock/release timing, divider reconfiguration,
// reset with pending update, out-of-range requests, channel disable and D=0.
module tb_pll_clkdiv_gen;

    logic       refclk;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [7:0] cfg_phase;
    logic       cfg_en;
    logic [3:0] clk_out;
    logic [3:0] clk_en;
    logic [3:0] rst_out;
    logic       extlock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // CH_W widened so an out-of-range channel number is representable.
    pll_clkdiv_gen #(
        .NUM_CH(4), .DIV_W(8), .DEF_DIV(1), .LOCK_CYCLES(16), .RST_STAGGER(4), .CH_W(3)
    ) dut (
        .refclk(refclk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_en(cfg_en),
        .clk_out(clk_out), .clk_en(clk_en), .rst_out(rst_out), .extlock(extlock)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic cfg(input logic [2:0] ch, input logic [7:0] dv, input logic [7:0] ph,
                       input logic en);
        int n;
        n = 0;
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = dv;
        cfg_phase = ph;
        cfg_en    = en;
        while (!cfg_ready && n < 50) begin
            step();
            n++;
        end
        chk("cfg_ready_wait", cfg_ready, 1);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_commit(output int n);
        n = 0;
        while (!cfg_ready && n < 100) begin
            step();
            n++;
        end
        chk("commit_wait", cfg_ready, 1);
    endtask

    initial begin
        int ext_rise;
        int fall[4];
        int exp_fall[4];
        int n;
        int other_bad;
        int run_len;
        int min_run;
        int first_run;
        int ones_o;
        int ones_e;
        logic [9:0]  pat_o;
        logic [9:0]  pat_e;
        logic        prev;

        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_phase = '0;
        cfg_en    = 1'b0;
        repeat (3) step();

        chk("rst_clk_out", clk_out, 4'h0);
        chk("rst_clk_en", clk_en, 4'h0);
        chk("rst_rst_out", rst_out, 4'hF);
        chk("rst_extlock", extlock, 0);
        chk("rst_cfg_ready", cfg_ready, 0);

        // Power-up: lock at T+17, releases every 4 cycles, period-2 clocks.
        reset    = 1'b0;
        cyc      = 0;
        ext_rise = 0;
        fall     = '{0, 0, 0, 0};
        exp_fall = '{17, 21, 25, 29};
        for (int k = 1; k <= 32; k++) begin
            step();
            if (extlock && ext_rise == 0) ext_rise = k;
            for (int j = 0; j < 4; j++)
                if (!rst_out[j] && fall[j] == 0) fall[j] = k;
            if (k == 1) chk("ready_in_settle", cfg_ready, 1);
            if (k == 4) begin
                chk("clk_out_even", clk_out, 4'hF);
                chk("clk_en_even", clk_en, 4'hF);
            end
            if (k == 5) begin
                chk("clk_out_odd", clk_out, 4'h0);
                chk("clk_en_odd", clk_en, 4'h0);
            end
        end
        chk("extlock_rise", ext_rise, 17);
        for (int j = 0; j < 4; j++)
            chk($sformatf("rst_fall%0d", j), fall[j], exp_fall[j]);

        // ch2 D=4 phase=2: 3 high / 2 low, strobe on 3rd cycle.
        cfg(3'd2, 8'd4, 8'd2, 1'b1);
        chk("acc_extlock", extlock, 0);
        chk("acc_rst_out", rst_out, 4'hF);
        chk("acc_ready", cfg_ready, 0);
        wait_commit(n);
        other_bad = 0;
        pat_o     = '0;
        pat_e     = '0;
        for (int j = 0; j < 10; j++) begin
            if (j > 0) step();
            pat_o[j] = clk_out[2];
            pat_e[j] = clk_en[2];
            if (clk_out[0] !== (cyc % 2 == 0)) other_bad++;
            if (clk_out[1] !== (cyc % 2 == 0)) other_bad++;
            if (clk_out[3] !== (cyc % 2 == 0)) other_bad++;
        end
        chk("ch2_clk_out_pat", pat_o, 10'h0E7);
        chk("ch2_clk_en_pat", pat_e, 10'h084);
        chk("others_undisturbed", other_bad, 0);

        // ch1 D=7, then D=9 accepted while cnt_1=0.
        cfg(3'd1, 8'd7, 8'd0, 1'b1);
        wait_commit(n);
        cfg(3'd1, 8'd9, 8'd0, 1'b1);
        chk("d9_acc_extlock", extlock, 0);
        ext_rise  = 0;
        n         = 0;
        prev      = clk_out[1];
        run_len   = 1;
        min_run   = 99;
        first_run = 1;
        for (int j = 1; j <= 40; j++) begin
            step();
            if (cfg_ready && n == 0) n = j;
            if (extlock && ext_rise == 0) ext_rise = j;
            if (clk_out[1] == prev) begin
                run_len++;
            end else begin
                if (!first_run && run_len < min_run) min_run = run_len;
                first_run = 0;
                run_len   = 1;
                prev      = clk_out[1];
            end
        end
        chk("d9_commit_delay", n, 7);
        chk("d9_extlock_rise", ext_rise, 23);
        chk("d9_min_run", min_run, 4);

        // Reset during SETTLE with a pending update.
        cfg(3'd0, 8'd3, 8'd0, 1'b1);
        wait_commit(n);
        cfg(3'd1, 8'd5, 8'd1, 1'b1);
        step();
        chk("pend_before_reset", cfg_ready, 0);
        reset = 1'b1;
        step();
        chk("mid_rst_clk_out", clk_out, 4'h0);
        chk("mid_rst_clk_en", clk_en, 4'h0);
        chk("mid_rst_rst_out", rst_out, 4'hF);
        chk("mid_rst_extlock", extlock, 0);
        chk("mid_rst_ready", cfg_ready, 0);
        reset = 1'b0;
        cyc   = 0;
        step();
        step();
        chk("post_rst_clk_hi", clk_out, 4'hF);
        step();
        chk("post_rst_clk_lo", clk_out, 4'h0);

        // Out-of-range channel during RELEASE: consumed, nothing changes.
        while (cyc < 20) step();
        cfg(3'd5, 8'd2, 8'd0, 1'b0);
        chk("oor_extlock", extlock, 1);
        chk("oor_ready", cfg_ready, 1);
        chk("oor_rst_out", rst_out, 4'hC);

        // Disable ch3: it stays low and in reset, releases stop after ch2.
        cfg(3'd3, 8'd1, 8'd0, 1'b0);
        chk("dis_rst_out", rst_out, 4'hF);
        chk("dis_extlock", extlock, 0);
        wait_commit(n);
        chk("dis_clk_out3", clk_out[3], 0);
        ext_rise = 0;
        fall     = '{0, 0, 0, 0};
        exp_fall = '{16, 20, 24, 0};
        ones_o   = 0;
        for (int j = 1; j <= 40; j++) begin
            step();
            if (extlock && ext_rise == 0) ext_rise = j;
            for (int c = 0; c < 4; c++)
                if (!rst_out[c] && fall[c] == 0) fall[c] = j;
            if (clk_out[3]) ones_o++;
        end
        chk("dis_extlock_rise", ext_rise, 16);
        for (int c = 0; c < 4; c++)
            chk($sformatf("dis_rst_fall%0d", c), fall[c], exp_fall[c]);
        chk("dis_clk3_ones", ones_o, 0);

        // ch0 D=0: both outputs constant high.
        cfg(3'd0, 8'd0, 8'd0, 1'b1);
        wait_commit(n);
        ones_o = 0;
        ones_e = 0;
        for (int j = 0; j < 8; j++) begin
            if (j > 0) step();
            if (clk_out[0]) ones_o++;
            if (clk_en[0]) ones_e++;
        end
        chk("d0_clk_out_high", ones_o, 8);
        chk("d0_clk_en_high", ones_e, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
